// File: rtl/breath_duty_gen_if.sv
// Bundle between a PWM period timer and the breathing-duty generator.
//
// Handshake: duty_vld is a one-cycle strobe that qualifies duty, state and
// cycle_done as fresh. There is no ready signal; the consumer must accept
// the value on the cycle it is strobed. period_tick is a one-cycle pulse
// from the PWM side marking a period wrap. enable is a plain level.
interface breath_duty_gen_if;

  logic        enable;
  logic        period_tick;
  logic [16:0] duty;
  logic        duty_vld;
  logic [2:0]  state;
  logic        cycle_done;

  // PWM / control side: drives enable and ticks, consumes the duty value
  modport master (
    output enable,
    output period_tick,
    input  duty,
    input  duty_vld,
    input  state,
    input  cycle_done
  );

  // Generator side
  modport slave (
    input  enable,
    input  period_tick,
    output duty,
    output duty_vld,
    output state,
    output cycle_done
  );

endinterface

// File: rtl/breath_duty_gen.sv
// Breathing-LED duty generator. Once per PWM period the duty value ramps up
// by STEP to PERIOD, dwells for HOLD_PERIODS periods, ramps down to 0 and
// dwells again, then repeats. enable low returns everything to idle at once.
module breath_duty_gen #(
  parameter int PERIOD       = 100000,
  parameter int STEP         = 50,
  parameter int HOLD_PERIODS = 200
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  breath_duty_gen_if.slave    bus
);

  // Dwell counter only ever needs to reach HOLD_PERIODS-1; keep at least 1 bit
  localparam int HC_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [16:0]     C_PERIOD    = 17'(PERIOD);
  localparam logic [16:0]     C_STEP      = 17'(STEP);
  localparam logic [HC_W-1:0] C_HOLD_LAST = (HOLD_PERIODS > 0) ? HC_W'(HOLD_PERIODS - 1) : '0;
  localparam logic            C_HOLD_ZERO = (HOLD_PERIODS == 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RISE    = 3'd1,
    S_HOLD_HI = 3'd2,
    S_FALL    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  state_t            r_state;
  logic [16:0]       r_duty;
  logic [HC_W-1:0]   r_hold_cnt;
  logic              r_duty_vld;
  logic              r_cycle_done;

  state_t            w_state_nxt;
  logic [16:0]       w_duty_nxt;
  logic [HC_W-1:0]   w_hold_cnt_nxt;
  logic              w_duty_vld_nxt;
  logic              w_cycle_done_nxt;

  logic [17:0]       w_rise_sum;
  logic [16:0]       w_rise_duty;
  logic [16:0]       w_fall_duty;
  logic              w_hold_done;
  logic              w_at_peak;
  logic              w_at_floor;

  // Ramp arithmetic: the upward sum carries an extra bit so a large STEP
  // near the top cannot wrap before it is clamped to PERIOD; the downward
  // step floors at zero instead of underflowing.
  always_comb begin
    w_rise_sum  = {1'b0, r_duty} + {1'b0, C_STEP};
    w_rise_duty = (w_rise_sum >= {1'b0, C_PERIOD}) ? C_PERIOD : w_rise_sum[16:0];
    w_fall_duty = (r_duty < C_STEP) ? 17'd0 : (r_duty - C_STEP);
    w_at_peak   = (r_duty == C_PERIOD);
    w_at_floor  = (r_duty == 17'd0);
    // A zero-length dwell still costs the one tick that leaves the hold state
    w_hold_done = C_HOLD_ZERO || (r_hold_cnt >= C_HOLD_LAST);
  end

  // Next-state and next-output logic; all movement is gated by period_tick
  // except the enable-low abort, which acts on the very next edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_duty_nxt       = r_duty;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_duty_vld_nxt   = 1'b0;
    w_cycle_done_nxt = 1'b0;

    if (!bus.enable) begin
      // Abort wins over a coincident tick; idle-to-idle stays silent
      if (r_state != S_IDLE) begin
        w_state_nxt    = S_IDLE;
        w_duty_nxt     = 17'd0;
        w_hold_cnt_nxt = '0;
        w_duty_vld_nxt = 1'b1;
      end
    end else if (bus.period_tick) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_RISE;
          w_duty_nxt     = 17'd0;
          w_hold_cnt_nxt = '0;
          w_duty_vld_nxt = 1'b1;
        end

        S_RISE: begin
          w_duty_vld_nxt = 1'b1;
          if (w_at_peak) begin
            w_state_nxt    = S_HOLD_HI;
            w_hold_cnt_nxt = '0;
          end else begin
            w_duty_nxt = w_rise_duty;
          end
        end

        S_HOLD_HI: begin
          w_duty_vld_nxt = 1'b1;
          if (w_hold_done) begin
            w_state_nxt    = S_FALL;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HC_W'(1);
          end
        end

        S_FALL: begin
          w_duty_vld_nxt = 1'b1;
          if (w_at_floor) begin
            w_state_nxt    = S_HOLD_LO;
            w_hold_cnt_nxt = '0;
          end else begin
            w_duty_nxt = w_fall_duty;
          end
        end

        S_HOLD_LO: begin
          w_duty_vld_nxt = 1'b1;
          if (w_hold_done) begin
            // Leaving the trough closes one full breath
            w_state_nxt      = S_RISE;
            w_hold_cnt_nxt   = '0;
            w_cycle_done_nxt = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HC_W'(1);
          end
        end

        default: begin
          // Unreachable encodings recover to idle with a clean duty
          w_state_nxt    = S_IDLE;
          w_duty_nxt     = 17'd0;
          w_hold_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers; reset overrides enable and tick
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_duty       <= 17'd0;
      r_hold_cnt   <= '0;
      r_duty_vld   <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_duty       <= w_duty_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_duty_vld   <= w_duty_vld_nxt;
      r_cycle_done <= w_cycle_done_nxt;
    end
  end

  assign bus.duty       = r_duty;
  assign bus.duty_vld   = r_duty_vld;
  assign bus.state      = r_state;
  assign bus.cycle_done = r_cycle_done;

endmodule

// File: tb/tb_breath_duty_gen.sv
// Bench for breath_duty_gen: two instances (a stepped ramp with dwell, and a
// single-step ramp with zero dwell) share stimulus and are compared every
// cycle against a table-driven model of one breath.
module tb_breath_duty_gen;

  localparam int P0 = 100, S0 = 30,  H0 = 2;
  localparam int P1 = 100, S1 = 100, H1 = 0;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  breath_duty_gen_if bus0 ();
  breath_duty_gen_if bus1 ();

  breath_duty_gen #(.PERIOD(P0), .STEP(S0), .HOLD_PERIODS(H0)) dut0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus0)
  );

  breath_duty_gen #(.PERIOD(P1), .STEP(S1), .HOLD_PERIODS(H1)) dut1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus1)
  );

  // ---------------- reference model ----------------
  // One breath, starting just after entering the ramp-up at duty 0, is laid
  // out as a list of (state, duty, done) results, one per processed tick.
  typedef struct packed {
    logic [2:0]  st;
    logic [16:0] d;
    logic        done;
  } ent_t;

  ent_t        tbl [2][64];
  int          tbl_len [2];

  logic        m_idle [2];
  int          m_idx  [2];
  logic [16:0] m_duty [2];
  logic [2:0]  m_st   [2];
  logic        m_vld  [2];
  logic        m_done [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic build_tbl(input int k, input int p, input int s, input int h);
    int d;
    int n;
    d = 0;
    n = 0;
    while (d < p) begin
      d = (d + s > p) ? p : d + s;
      tbl[k][n] = '{3'd1, 17'(d), 1'b0}; n++;
    end
    tbl[k][n] = '{3'd2, 17'(p), 1'b0}; n++;
    for (int i = 0; i < h - 1; i++) begin
      tbl[k][n] = '{3'd2, 17'(p), 1'b0}; n++;
    end
    tbl[k][n] = '{3'd3, 17'(p), 1'b0}; n++;
    while (d > 0) begin
      d = (d < s) ? 0 : d - s;
      tbl[k][n] = '{3'd3, 17'(d), 1'b0}; n++;
    end
    tbl[k][n] = '{3'd4, 17'd0, 1'b0}; n++;
    for (int i = 0; i < h - 1; i++) begin
      tbl[k][n] = '{3'd4, 17'd0, 1'b0}; n++;
    end
    tbl[k][n] = '{3'd1, 17'd0, 1'b1}; n++;
    tbl_len[k] = n;
  endtask

  task automatic model_edge(input int k, input logic rst, input logic en, input logic tick);
    m_vld[k]  = 1'b0;
    m_done[k] = 1'b0;
    if (rst) begin
      m_idle[k] = 1'b1; m_duty[k] = '0; m_st[k] = 3'd0;
    end else if (!en) begin
      if (!m_idle[k]) begin
        m_idle[k] = 1'b1; m_duty[k] = '0; m_st[k] = 3'd0; m_vld[k] = 1'b1;
      end
    end else if (tick) begin
      m_vld[k] = 1'b1;
      if (m_idle[k]) begin
        m_idle[k] = 1'b0; m_idx[k] = 0; m_duty[k] = '0; m_st[k] = 3'd1;
      end else begin
        m_st[k]   = tbl[k][m_idx[k]].st;
        m_duty[k] = tbl[k][m_idx[k]].d;
        m_done[k] = tbl[k][m_idx[k]].done;
        m_idx[k]  = (m_idx[k] + 1) % tbl_len[k];
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("d0_duty",  32'(bus0.duty),       32'(m_duty[0]));
    chk("d0_vld",   32'(bus0.duty_vld),   32'(m_vld[0]));
    chk("d0_state", 32'(bus0.state),      32'(m_st[0]));
    chk("d0_done",  32'(bus0.cycle_done), 32'(m_done[0]));
    chk("d1_duty",  32'(bus1.duty),       32'(m_duty[1]));
    chk("d1_vld",   32'(bus1.duty_vld),   32'(m_vld[1]));
    chk("d1_state", 32'(bus1.state),      32'(m_st[1]));
    chk("d1_done",  32'(bus1.cycle_done), 32'(m_done[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst, input logic en, input logic tick);
    @(negedge sys_clk);
    sys_rst          = rst;
    bus0.enable      = en;
    bus0.period_tick = tick;
    bus1.enable      = en;
    bus1.period_tick = tick;
    @(posedge sys_clk);
    model_edge(0, rst, en, tick);
    model_edge(1, rst, en, tick);
    #1;
    check_all();
  endtask

  // One tick after a short random gap of idle cycles
  task automatic tick_once(input logic en);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) step(1'b0, en, 1'b0);
    step(1'b0, en, 1'b1);
  endtask

  int exp_ramp [12];
  int vld_cnt;
  logic en_r;

  initial begin
    exp_ramp = '{0, 30, 60, 90, 100, 100, 100, 100, 70, 40, 10, 0};
    build_tbl(0, P0, S0, H0);
    build_tbl(1, P1, S1, H1);
    for (int k = 0; k < 2; k++) begin
      m_idle[k] = 1'b1; m_idx[k] = 0; m_duty[k] = '0;
      m_st[k] = '0; m_vld[k] = 1'b0; m_done[k] = 1'b0;
    end
    bus0.enable = 1'b1; bus0.period_tick = 1'b0;
    bus1.enable = 1'b1; bus1.period_tick = 1'b0;

    // Reset held with enable high and ticks present
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_duty",  32'(bus0.duty),     32'd0);
    chk("rst_state", 32'(bus0.state),    32'd0);
    chk("rst_vld",   32'(bus0.duty_vld), 32'd0);

    // Full breath with 16 ticks
    for (int t = 0; t < 16; t++) begin
      tick_once(1'b1);
      if (t < 12) chk($sformatf("ramp_t%0d", t + 1), 32'(bus0.duty), 32'(exp_ramp[t]));
    end
    chk("breath_state", 32'(bus0.state), 32'd1);

    // Freeze in the ramp at duty 60
    step(1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) tick_once(1'b1);
    vld_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus0.duty_vld) vld_cnt++;
    end
    chk("freeze_duty", 32'(bus0.duty), 32'd60);
    chk("freeze_vld",  32'(vld_cnt),   32'd0);

    // Enable drop coincident with a tick while falling at 70
    for (int t = 0; t < 6; t++) tick_once(1'b1);
    chk("fall70_duty",  32'(bus0.duty),  32'd70);
    chk("fall70_state", 32'(bus0.state), 32'd3);
    step(1'b0, 1'b0, 1'b1);
    chk("drop_duty",  32'(bus0.duty),     32'd0);
    chk("drop_state", 32'(bus0.state),    32'd0);
    vld_cnt = bus0.duty_vld ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'(i % 2));
      if (bus0.duty_vld) vld_cnt++;
    end
    chk("drop_vld_pulses", 32'(vld_cnt), 32'd1);

    // Reset in the high dwell, then restart
    for (int t = 0; t < 6; t++) tick_once(1'b1);
    chk("hold_hi_state", 32'(bus0.state), 32'd2);
    step(1'b1, 1'b1, 1'b1);
    chk("midrst_duty",  32'(bus0.duty),  32'd0);
    chk("midrst_state", 32'(bus0.state), 32'd0);
    for (int t = 0; t < 3; t++) begin
      tick_once(1'b1);
      chk($sformatf("restart_t%0d", t + 1), 32'(bus0.duty), 32'(exp_ramp[t]));
    end

    // Randomized traffic: sparse resets, slow enable toggling, frequent ticks
    en_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) en_r = ~en_r;
      step(($urandom_range(0, 399) == 0), en_r, ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
